// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   W_DEF    default operand width
//   OP_*     3-bit operation encodings driven on muldiv_unit.op
//   state_t  controller states (IDLE -> CALC -> FIX -> IDLE)
//   abs_w()  conditional two's-complement negate. It is used to take operand
//            magnitudes and to apply the sign fix-up to results.
package muldiv_pkg;

    localparam int W_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Negate x when neg is set. With neg = sign bit this yields |x|.
    // The width is 2*W_DEF so one function serves both W-bit operands and
    // 2W-bit products. Callers zero-extend and truncate with casts.
    function automatic logic [2*W_DEF-1:0] abs_w(input logic [2*W_DEF-1:0] x,
                                                 input logic               neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that owns the HI/LO registers.
//   MULT/MULTU use an unsigned shift-add over W cycles.
//   DIV/DIVU use a restoring shift-subtract over W cycles.
//   Both paths end with a one-cycle sign fix-up and commit.
//   MTHI/MTLO write hi/lo directly in a single cycle.
// Configuration macro: MULDIV_DIV_EN.
//   Defined:   the divide datapath is built.
//   Undefined: ops 2/3 are ignored like the reserved ops.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   start, op    request and operation code
//   a, b         operands (rs / rt). They are captured on the accepting edge.
//   hi, lo       HI/LO architectural registers
//   busy         a multi-cycle operation is in flight
//   done         one-cycle pulse when hi/lo are committed by MULT*/DIV*
// Handshake: start is sampled only on an edge where busy==0. A start seen
// while busy==1 is dropped, not queued. busy rises on the accepting edge and
// falls on the same edge that raises done. A new start may therefore be
// accepted during the done cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         done
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    // During a multiply, the upper half holds the partial product and the
    // lower half holds the remaining multiplier bits.
    // During a divide, the upper half holds the remainder and the lower half
    // holds dividend bits that shift out as quotient bits shift in.
    logic [2*W-1:0]   acc;
    logic [W-1:0]     mag_b;
    logic             neg_res;

    logic             op_md;
    logic             op_signed;
    logic [W-1:0]     mag_a_in;
    logic [W-1:0]     mag_b_in;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   acc_step;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     res_hi;
    logic [W-1:0]     res_lo;

`ifdef MULDIV_DIV_EN
    logic             is_div;
    logic             neg_rem;
    logic             div_zero;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic [W-1:0]     quo;
    logic [W-1:0]     rem;
`endif

    // Operation decode and operand magnitudes.
    always_comb begin
        op_md = (op == OP_MULT) || (op == OP_MULTU)
`ifdef MULDIV_DIV_EN
             || (op == OP_DIV) || (op == OP_DIVU)
`endif
             ;
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        mag_a_in  = W'(abs_w((2*W_DEF)'(a), op_signed && a[W-1]));
        mag_b_in  = W'(abs_w((2*W_DEF)'(b), op_signed && b[W-1]));
    end

    // One iteration of the active datapath, plus the final fix-up values.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? mag_b : {W{1'b0}})};
        acc_step = {mul_sum, acc[W-1:1]};
        prod     = (2*W)'(abs_w((2*W_DEF)'(acc), neg_res));
        res_hi   = prod[2*W-1:W];
        res_lo   = prod[W-1:0];
`ifdef MULDIV_DIV_EN
        // Restoring step: the shifted remainder is W+1 bits, so the borrow
        // bit of the subtraction decides the quotient bit.
        div_shift = acc[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, mag_b};
        quo       = W'(abs_w((2*W_DEF)'(acc[W-1:0]), neg_res));
        // For a zero divisor the remainder ends up as |a|. Giving it the
        // dividend's sign restores the raw a, so only lo needs an override.
        rem       = W'(abs_w((2*W_DEF)'(acc[2*W-1:W]), neg_rem));
        if (is_div) begin
            if (!div_diff[W]) acc_step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
            else              acc_step = {div_shift[W-1:0], acc[W-2:0], 1'b0};
            res_hi = rem;
            res_lo = div_zero ? {W{1'b1}} : quo;
        end
`endif
    end

    // Controller: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Controller: next state and busy.
    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: if (start && op_md) state_next = ST_CALC;
            ST_CALC: if (cnt == CNT_W'(W-1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            mag_b    <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && op_md) begin
                        acc     <= {{W{1'b0}}, mag_a_in};
                        mag_b   <= mag_b_in;
                        cnt     <= '0;
                        neg_res <= op_signed && (a[W-1] ^ b[W-1]);
`ifdef MULDIV_DIV_EN
                        is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                        neg_rem  <= op_signed && a[W-1];
                        div_zero <= (b == '0);
`endif
                    end else if (start && op == OP_MTHI) begin
                        hi <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                ST_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                ST_FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit.
// The driver pushes the hand-computed {hi,lo} for every MULT/DIV request
// into exp_q. A negedge monitor pops and compares the queue whenever done
// is high. Latency, busy, ignored-request and reset behaviour are checked
// inline by the driver.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    logic [2*W-1:0] exp_q[$];
    int             tests;
    int             fails;
    logic [W-1:0]   m_hi;
    logic [W-1:0]   m_lo;

    muldiv_unit #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("result_hi_lo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic run_md(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
        int n;
        int bc;
        issue(o, va, vb);
        exp_q.push_back({e_hi, e_lo});
        m_hi = e_hi;
        m_lo = e_lo;
        wait_done(n, bc);
    endtask

    task automatic run_ignored(input string name, input logic [2:0] o);
        issue(o, 32'h1357_9BDF, 32'h0000_0002);
        check({name, "_busy_now"}, {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_busy_later"}, {63'd0, busy}, 64'd0);
        check({name, "_hi_lo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        int n;
        int bc;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);

        // Test 1: full-scale unsigned product, latency and busy width.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        m_hi = 32'hFFFF_FFFE;
        m_lo = 32'h0000_0001;
        wait_done(n, bc);
        check("multu_latency", 64'(n), 64'd33);
        check("multu_busy_cycles", 64'(bc), 64'd33);
        @(posedge clk);
        #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // Test 2: signed products.
        run_md(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_md(OP_MULT, 32'h0000_1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_F000);

`ifdef MULDIV_DIV_EN
        // Tests 3-4: divides, divide by zero, signed overflow.
        run_md(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md(OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md(OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14);
        run_md(OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
        run_md(OP_DIV,  32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_md(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`else
        // Without the divide datapath, ops 2/3 behave as reserved.
        run_ignored("div_disabled", OP_DIV);
        run_ignored("divu_disabled", OP_DIVU);
`endif

        // Reserved opcodes are ignored.
        run_ignored("op6", 3'd6);
        run_ignored("op7", 3'd7);

        // Test 5: a start pulse during busy is dropped.
        issue(OP_MULT, 32'd6, 32'd7);
        exp_q.push_back({32'd0, 32'd42});
        m_hi = 32'd0;
        m_lo = 32'd42;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'h0000_1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, bc);

        issue(OP_MTHI, 32'h0000_1234, 32'h0);
        m_hi = 32'h0000_1234;
        check("mthi_hi_lo", {hi, lo}, {m_hi, m_lo});
        check("mthi_no_done", {63'd0, done}, 64'd0);
        check("mthi_no_busy", {63'd0, busy}, 64'd0);
        issue(OP_MTLO, 32'hCAFE_0001, 32'h0);
        m_lo = 32'hCAFE_0001;
        check("mtlo_hi_lo", {hi, lo}, {m_hi, m_lo});

        // Test 6: reset at CALC iteration 10 aborts with no done.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_hi_lo", {hi, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_commit", {hi, lo}, 64'd0);

        run_md(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'h0000_000C);

        repeat (2) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
